wishbone_master_bridge: RTL

Upstream master stage for the wishbone interconnect. Accepts word-count commands from a host-side stream interface and turns them into sequences of single-beat Wishbone classic cycles on the interconnect's master port. Write data and read data move over valid/ready streams. Bus stalls are aborted by an optional ack timeout.

---
 rtl/wishbone_master_bridge.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wishbone_master_bridge.sv
// Host-stream to Wishbone classic master bridge: word-count commands become single-beat bus cycles.
// Optional ack timeout is compiled in with `define WB_MASTER_TIMEOUT_EN.
module wishbone_master_bridge #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_adr,
  input  logic [7:0]  cmd_len,
  input  logic        wdat_valid,
  output logic        wdat_ready,
  input  logic [31:0] wdat,
  output logic        rdat_valid,
  input  logic        rdat_ready,
  output logic [31:0] rdat,
  output logic        done,
  output logic        err,
  output logic        host_int,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_int_i
);

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    BUS,
    RDATA,
    FIN
  } state_t;

  state_t      state, state_nxt;
  logic        dir, dir_nxt;
  logic [7:0]  beats;
  logic        accept, wdat_hs, rdat_hs, ack, advance, timeout_hit, cyc_nxt;

`ifdef WB_MASTER_TIMEOUT_EN
  logic [15:0] tcnt;
`else
  logic        unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

  assign accept  = (state == IDLE) && cmd_valid && cmd_ready;
  assign wdat_hs = (state == WDATA) && wdat_valid && wdat_ready;
  assign rdat_hs = (state == RDATA) && rdat_valid && rdat_ready;
  assign ack     = (state == BUS) && m_stb_o && m_ack_i;

  always_comb begin
    timeout_hit = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    // Ack on the expiry cycle takes priority over the abort.
    timeout_hit = (state == BUS) && !ack && (tcnt == (TIMEOUT - 16'd1));
`endif
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          dir_nxt   = cmd_wr;
          state_nxt = cmd_wr ? WDATA : BUS;
        end
      end
      WDATA: begin
        if (wdat_hs) state_nxt = BUS;
      end
      BUS: begin
        if (ack) begin
          if (!dir) begin
            state_nxt = RDATA;
          end else if (beats == 8'd0) begin
            state_nxt = FIN;
          end else begin
            state_nxt = WDATA;
            advance   = 1'b1;
          end
        end else if (timeout_hit) begin
          state_nxt = FIN;
        end
      end
      RDATA: begin
        if (rdat_hs) begin
          if (beats == 8'd0) begin
            state_nxt = FIN;
          end else begin
            state_nxt = BUS;
            advance   = 1'b1;
          end
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cyc rises on the first BUS entry and is held across WDATA/RDATA gaps until FIN.
  assign cyc_nxt = (state_nxt == BUS) ||
                   (m_cyc_o && ((state_nxt == WDATA) || (state_nxt == RDATA)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dir        <= 1'b0;
      beats      <= '0;
      cmd_ready  <= 1'b0;
      wdat_ready <= 1'b0;
      rdat_valid <= 1'b0;
      rdat       <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      host_int   <= 1'b0;
      m_we_o     <= 1'b0;
      m_cyc_o    <= 1'b0;
      m_stb_o    <= 1'b0;
      m_adr_o    <= '0;
      m_dat_o    <= '0;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      cmd_ready  <= (state_nxt == IDLE);
      wdat_ready <= (state_nxt == WDATA);
      rdat_valid <= (state_nxt == RDATA);
      done       <= (state_nxt == FIN);
      err        <= (state_nxt == FIN) && timeout_hit;
      host_int   <= m_int_i;
      m_stb_o    <= (state_nxt == BUS);
      m_cyc_o    <= cyc_nxt;
      m_we_o     <= cyc_nxt && dir_nxt;
      if (accept) begin
        m_adr_o <= cmd_adr;
        beats   <= cmd_len;
      end
      if (wdat_hs) m_dat_o <= wdat;
      if (ack && !dir) rdat <= m_dat_i;
      if (advance) begin
        beats   <= beats - 8'd1;
        m_adr_o <= {m_adr_o[31:24], m_adr_o[23:0] + 24'd1};
      end
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (state != BUS) begin
      tcnt <= '0;
    end else if (!ack) begin
      tcnt <= tcnt + 16'd1;
    end
  end
`endif

endmodule
